// File: rtl/gate_lane_arbiter.sv
// ============================================================================
// Module      : gate_lane_arbiter
// Description : Shares one barrier-gate controller between an entry lane (0)
//               and an exit lane (1). It grants one lane at a time, forwards
//               that lane's signals, and follows the gate through the open,
//               passage and lock phases. Defining ARB_PRIORITY_EXIT_EN gives
//               lane 1 fixed priority; otherwise ties go round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_lane_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int PIN_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Req,
  input  logic [1:0]       EnterPin,
  input  logic [PIN_W-1:0] Pin0,
  input  logic [PIN_W-1:0] Pin1,
  input  logic [1:0]       Paso,
  input  logic             G_Abierto,
  input  logic             G_Bloqueo,
  output logic             G_Vehiculo,
  output logic [PIN_W-1:0] G_Pin,
  output logic             G_enterPin,
  output logic             G_Termino,
  output logic [1:0]       Grant,
  output logic             Busy,
  output logic             Timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMR_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_OPEN    = 3'd2,
    S_RELEASE = 3'd3,
    S_LOCK    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             timeout_q, timeout_d;

  logic             lane_g;
  logic             req_g;
  logic             enter_g;
  logic             paso_g;
  logic [PIN_W-1:0] pin_g;
  logic             pick;

  // Grant is one-hot, so bit 1 alone identifies the granted lane.
  assign lane_g  = grant_q[1];
  assign req_g   = Req[lane_g];
  assign enter_g = EnterPin[lane_g];
  assign paso_g  = Paso[lane_g];
  assign pin_g   = lane_g ? Pin1 : Pin0;

`ifdef ARB_PRIORITY_EXIT_EN
  assign pick = Req[1];
`else
  logic last_q, last_d;

  // On a tie the lane that did not go last wins.
  assign pick   = (Req == 2'b11) ? ~last_q : Req[1];
  assign last_d = ((grant_q != 2'b00) && (grant_d == 2'b00)) ? lane_g : last_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    timer_d    = '0;
    timeout_d  = 1'b0;
    G_Vehiculo = 1'b0;
    G_Pin      = '0;
    G_enterPin = 1'b0;
    G_Termino  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|Req) begin
          grant_d = pick ? 2'b10 : 2'b01;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        G_Vehiculo = req_g;
        G_Pin      = pin_g;
        G_enterPin = enter_g;
        if (enter_g) begin
          timer_d = '0;
        end else if (timer_q == TMR_MAX) begin
          timer_d = timer_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        // Gate opening wins over a vehicle leaving or the timer expiring.
        if (G_Abierto) begin
          state_d = S_OPEN;
          timer_d = '0;
        end else if (!req_g) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end else if (timer_q == TMR_LAST) begin
          state_d   = S_IDLE;
          grant_d   = 2'b00;
          timeout_d = 1'b1;
        end
      end

      S_OPEN: begin
        G_Vehiculo = req_g;
        G_Pin      = pin_g;
        G_Termino  = paso_g;
        if (paso_g) begin
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        G_Pin = pin_g;
        if (G_Bloqueo) begin
          state_d = S_LOCK;
        end else begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end
      end

      S_LOCK: begin
        G_Vehiculo = req_g;
        G_Pin      = pin_g;
        G_enterPin = enter_g;
        if (G_Abierto) begin
          state_d = S_OPEN;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign Grant   = grant_q;
  assign Busy    = (state_q != S_IDLE);
  assign Timeout = timeout_q;

  a_grant_onehot0 : assert property (@(posedge Clk) disable iff (Reset)
    grant_q != 2'b11);
  a_busy_matches_grant : assert property (@(posedge Clk) disable iff (Reset)
    (state_q == S_IDLE) == (grant_q == 2'b00));

endmodule

`default_nettype wire

// File: tb/tb_gate_lane_arbiter.sv
// ============================================================================
// Module      : tb_gate_lane_arbiter
// Description : Directed self-checking bench for gate_lane_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_lane_arbiter;

  localparam int PIN_W = 8;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [1:0]       Req;
  logic [1:0]       EnterPin;
  logic [PIN_W-1:0] Pin0;
  logic [PIN_W-1:0] Pin1;
  logic [1:0]       Paso;
  logic             G_Abierto;
  logic             G_Bloqueo;
  logic             G_Vehiculo;
  logic [PIN_W-1:0] G_Pin;
  logic             G_enterPin;
  logic             G_Termino;
  logic [1:0]       Grant;
  logic             Busy;
  logic             Timeout;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef ARB_PRIORITY_EXIT_EN
  localparam logic [1:0] FIRST_TIE = 2'b10;
`else
  localparam logic [1:0] FIRST_TIE = 2'b01;
`endif

  gate_lane_arbiter #(.TIMEOUT_CYC(16), .PIN_W(PIN_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .EnterPin   (EnterPin),
    .Pin0       (Pin0),
    .Pin1       (Pin1),
    .Paso       (Paso),
    .G_Abierto  (G_Abierto),
    .G_Bloqueo  (G_Bloqueo),
    .G_Vehiculo (G_Vehiculo),
    .G_Pin      (G_Pin),
    .G_enterPin (G_enterPin),
    .G_Termino  (G_Termino),
    .Grant      (Grant),
    .Busy       (Busy),
    .Timeout    (Timeout)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Req = 2'b00; EnterPin = 2'b00; Paso = 2'b00;
    Pin0 = '0; Pin1 = '0; G_Abierto = 1'b0; G_Bloqueo = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++; if (Grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", Grant); end
    n_assert++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_assert++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", Timeout); end
    n_assert++; if ({G_Vehiculo, G_enterPin, G_Termino, G_Pin} !== 11'd0) begin n_fail++; $display("FAIL reset_gouts: got %b%b%b %h want all 0", G_Vehiculo, G_enterPin, G_Termino, G_Pin); end
  endtask

  task automatic test_single_lane();
    do_reset();
    Req = 2'b01; Pin0 = 8'h08; Pin1 = 8'h55;
    tick();
    n_assert++; if (Grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", Grant); end
    n_assert++; if (G_Pin !== 8'h08) begin n_fail++; $display("FAIL single_pin: got %h want 08", G_Pin); end
    n_assert++; if (G_Vehiculo !== 1'b1) begin n_fail++; $display("FAIL single_veh: got %b want 1", G_Vehiculo); end
    EnterPin = 2'b01; #1;
    n_assert++; if (G_enterPin !== 1'b1) begin n_fail++; $display("FAIL single_enter: got %b want 1", G_enterPin); end
    tick();
    EnterPin = 2'b00;
    tick();
    G_Abierto = 1'b1;
    tick();
    G_Abierto = 1'b0;
    EnterPin = 2'b01; #1;
    n_assert++; if (G_enterPin !== 1'b0) begin n_fail++; $display("FAIL open_enter_blocked: got %b want 0", G_enterPin); end
    EnterPin = 2'b00;
    Req = 2'b00; Paso = 2'b01; #1;
    n_assert++; if (G_Termino !== 1'b1) begin n_fail++; $display("FAIL open_termino: got %b want 1", G_Termino); end
    tick();
    Paso = 2'b00; #1;
    n_assert++; if (G_Termino !== 1'b0) begin n_fail++; $display("FAIL release_termino: got %b want 0", G_Termino); end
    n_assert++; if (G_Pin !== 8'h08) begin n_fail++; $display("FAIL release_pin: got %h want 08", G_Pin); end
    n_assert++; if (Grant !== 2'b01) begin n_fail++; $display("FAIL release_grant: got %b want 01", Grant); end
    tick();
    n_assert++; if (Grant !== 2'b00 || Busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got grant %b busy %b want 00 0", Grant, Busy); end
    n_assert++; if (G_Pin !== 8'h00) begin n_fail++; $display("FAIL idle_pin: got %h want 00", G_Pin); end
  endtask

  task automatic test_req_drop();
    do_reset();
    Req = 2'b10; Pin1 = 8'h3C;
    tick();
    n_assert++; if (Grant !== 2'b10 || G_Pin !== 8'h3C) begin n_fail++; $display("FAIL drop_grant: got %b %h want 10 3c", Grant, G_Pin); end
    Req = 2'b00;
    tick();
    n_assert++; if (Grant !== 2'b00 || Timeout !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got grant %b tmo %b want 00 0", Grant, Timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    Req = 2'b01;
    tick();
    Req = 2'b11;
    for (int i = 0; i < 15; i++) tick();
    n_assert++; if (Grant !== 2'b01 || Timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_before: got grant %b tmo %b want 01 0", Grant, Timeout); end
    tick();
    n_assert++; if (Grant !== 2'b00 || Timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_fire: got grant %b tmo %b want 00 1", Grant, Timeout); end
    tick();
    n_assert++; if (Grant !== 2'b10 || Timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_after: got grant %b tmo %b want 10 0", Grant, Timeout); end
  endtask

  task automatic test_lock();
    do_reset();
    Req = 2'b01; Pin0 = 8'h21; Pin1 = 8'hAA;
    tick();
    G_Abierto = 1'b1;
    tick();
    G_Abierto = 1'b0;
    Paso = 2'b01; G_Bloqueo = 1'b1;
    tick();
    Paso = 2'b00; #1;
    n_assert++; if (G_Vehiculo !== 1'b0 || G_Pin !== 8'h21) begin n_fail++; $display("FAIL release_outs: got veh %b pin %h want 0 21", G_Vehiculo, G_Pin); end
    tick();
    G_Bloqueo = 1'b0;
    Req = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    n_assert++; if (Grant !== 2'b01 || Busy !== 1'b1) begin n_fail++; $display("FAIL lock_hold: got grant %b busy %b want 01 1", Grant, Busy); end
    n_assert++; if (G_Pin !== 8'h21 || G_Vehiculo !== 1'b1) begin n_fail++; $display("FAIL lock_outs: got pin %h veh %b want 21 1", G_Pin, G_Vehiculo); end
    G_Abierto = 1'b1;
    tick();
    G_Abierto = 1'b0;
    Paso = 2'b10; #1;
    n_assert++; if (G_Termino !== 1'b0 || Grant !== 2'b01) begin n_fail++; $display("FAIL lock_reopen_other: got term %b grant %b want 0 01", G_Termino, Grant); end
    Paso = 2'b01; #1;
    n_assert++; if (G_Termino !== 1'b1) begin n_fail++; $display("FAIL lock_reopen_term: got %b want 1", G_Termino); end
    Paso = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    Req = 2'b11; Pin0 = 8'h77;
    tick();
    G_Abierto = 1'b1;
    tick();
    G_Abierto = 1'b0;
    Paso = 2'b11;
    Reset = 1'b1;
    tick();
    n_assert++; if (Grant !== 2'b00 || Busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got grant %b busy %b want 00 0", Grant, Busy); end
    n_assert++; if ({G_Vehiculo, G_enterPin, G_Termino, G_Pin} !== 11'd0) begin n_fail++; $display("FAIL midrst_gouts: got %b%b%b %h want all 0", G_Vehiculo, G_enterPin, G_Termino, G_Pin); end
    Reset = 1'b0; Paso = 2'b00;
    tick();
    n_assert++; if (Grant !== FIRST_TIE) begin n_fail++; $display("FAIL midrst_tie: got %b want %b", Grant, FIRST_TIE); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [3];
`ifdef ARB_PRIORITY_EXIT_EN
    exp_seq = '{2'b10, 2'b10, 2'b10};
`else
    exp_seq = '{2'b01, 2'b10, 2'b01};
`endif
    do_reset();
    Req = 2'b11;
    tick();
    for (int r = 0; r < 3; r++) begin
      n_assert++; if (Grant !== exp_seq[r]) begin n_fail++; $display("FAIL b2b_round%0d: got %b want %b", r, Grant, exp_seq[r]); end
      G_Abierto = 1'b1;
      tick();
      G_Abierto = 1'b0;
      Paso = Grant;
      tick();
      Paso = 2'b00;
      tick();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_req_drop();
    test_timeout();
    test_lock();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
